fir_coeff_ctrl: RTL and testbench

- Reconfiguration sequencer that sits between the sample source, the `fir` filter and the sample sink.
- In normal operation it passes samples through to the filter and filtered samples on to the sink.
- On a reload request it:
  - halts input;
  - drains the filter output;
  - writes a new coefficient set from a coefficient stream into the filter's coefficient port;
  - optionally flushes the delay line with zeros;
  - then resumes traffic.
- Purpose: guarantees that no output sample is ever computed from a mix of old and new coefficients.

---
 rtl/fir_coeff_ctrl_if.sv | 53 +++++
 rtl/fir_coeff_ctrl.sv | 152 +++++++++++++++
 tb/tb_fir_coeff_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_ctrl_if.sv
// Stream bundle around fir_coeff_ctrl: coefficient, upstream, filter-in, filter-out, downstream.
// The sequencer takes the slave modport; the surrounding system takes master.
interface fir_coeff_ctrl_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COEFF_WIDTH = 16
);
  logic [COEFF_WIDTH-1:0] c_tdata;
  logic                   c_tvalid;
  logic                   c_tready;
  logic                   c_tlast;

  logic [DATA_WIDTH-1:0]  up_tdata;
  logic                   up_tvalid;
  logic                   up_tready;

  logic [DATA_WIDTH-1:0]  fir_s_tdata;
  logic                   fir_s_tvalid;
  logic                   fir_s_tready;

  logic [DATA_WIDTH-1:0]  fir_m_tdata;
  logic                   fir_m_tvalid;
  logic                   fir_m_tready;

  logic [DATA_WIDTH-1:0]  dn_tdata;
  logic                   dn_tvalid;
  logic                   dn_tready;

  modport slave (
    input  c_tdata, c_tvalid, c_tlast,
    output c_tready,
    input  up_tdata, up_tvalid,
    output up_tready,
    output fir_s_tdata, fir_s_tvalid,
    input  fir_s_tready,
    input  fir_m_tdata, fir_m_tvalid,
    output fir_m_tready,
    output dn_tdata, dn_tvalid,
    input  dn_tready
  );

  modport master (
    output c_tdata, c_tvalid, c_tlast,
    input  c_tready,
    output up_tdata, up_tvalid,
    input  up_tready,
    input  fir_s_tdata, fir_s_tvalid,
    output fir_s_tready,
    output fir_m_tdata, fir_m_tvalid,
    input  fir_m_tready,
    input  dn_tdata, dn_tvalid,
    output dn_tready
  );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient reload sequencer: halts input, drains, loads a new coefficient set, resumes.
// Define FIR_COEFF_CTRL_FLUSH_EN to zero-flush the delay line (FLUSH/DRAIN) after loading.
module fir_coeff_ctrl #(
  parameter int unsigned NUM_TAPS    = 33,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COEFF_WIDTH = 16,
  localparam int unsigned IdxW       = $clog2(NUM_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  fir_coeff_ctrl_if.slave        bus,
  input  logic                   cfg_start,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   coeff_wr_en,
  output logic [IdxW-1:0]        coeff_idx,
  output logic [COEFF_WIDTH-1:0] coeff_w
);

  typedef enum logic [2:0] {
    StRun,
    StHalt,
    StLoad,
    StFlush,
    StDrain,
    StDone
  } state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_TAPS - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  state_e                 state_q;
  logic [IdxW-1:0]        cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic                   wr_en_q;
  logic [IdxW-1:0]        idx_q;
  logic [COEFF_WIDTH-1:0] w_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      idx_q   <= '0;
      w_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        StRun: begin
          if (cfg_start) begin
            state_q <= StHalt;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StHalt: begin
          if (!bus.fir_m_tvalid) state_q <= StLoad;
        end
        StLoad: begin
          if (bus.c_tvalid) begin
            wr_en_q <= 1'b1;
            idx_q   <= cnt_q;
            w_q     <= bus.c_tdata;
            if ((cnt_q == LastIdx) || bus.c_tlast) begin
              cnt_q <= '0;
              // tlast must coincide exactly with the final tap
              if (bus.c_tlast != (cnt_q == LastIdx)) err_q <= 1'b1;
`ifdef FIR_COEFF_CTRL_FLUSH_EN
              state_q <= StFlush;
`else
              state_q <= StDone;
`endif
            end else begin
              cnt_q <= cnt_q + IdxOne;
            end
          end
        end
`ifdef FIR_COEFF_CTRL_FLUSH_EN
        StFlush: begin
          if (bus.fir_s_tready) begin
            if (cnt_q == LastIdx) begin
              cnt_q   <= '0;
              state_q <= StDrain;
            end else begin
              cnt_q <= cnt_q + IdxOne;
            end
          end
        end
        StDrain: begin
          if (!bus.fir_m_tvalid) state_q <= StDone;
        end
`endif
        StDone: begin
          state_q <= StRun;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Stream steering: pass-through in RUN, input gated otherwise, output discarded once
  // loading starts so nothing computed across the coefficient change reaches the sink.
  always_comb begin
    bus.c_tready     = 1'b0;
    bus.up_tready    = 1'b0;
    bus.fir_s_tvalid = 1'b0;
    bus.fir_s_tdata  = bus.up_tdata;
    bus.fir_m_tready = bus.dn_tready;
    bus.dn_tvalid    = bus.fir_m_tvalid;
    bus.dn_tdata     = bus.fir_m_tdata;
    case (state_q)
      StRun: begin
        bus.up_tready    = bus.fir_s_tready;
        bus.fir_s_tvalid = bus.up_tvalid;
      end
      StLoad: begin
        bus.c_tready     = 1'b1;
        bus.fir_m_tready = 1'b1;
        bus.dn_tvalid    = 1'b0;
      end
      StFlush: begin
        bus.fir_s_tvalid = 1'b1;
        bus.fir_s_tdata  = {DATA_WIDTH{1'b0}};
        bus.fir_m_tready = 1'b1;
        bus.dn_tvalid    = 1'b0;
      end
      StDrain: begin
        bus.fir_m_tready = 1'b1;
        bus.dn_tvalid    = 1'b0;
      end
      default: ;
    endcase
  end

  assign cfg_busy    = busy_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign coeff_wr_en = wr_en_q;
  assign coeff_idx   = idx_q;
  assign coeff_w     = w_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Bench for fir_coeff_ctrl with a 4-tap behavioural Q1.15 FIR on the filter ports.
module tb_fir_coeff_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cfg_start;
  logic          cfg_busy, cfg_done, cfg_err;
  logic          coeff_wr_en;
  logic [IW-1:0] coeff_idx;
  logic [CW-1:0] coeff_w;

  fir_coeff_ctrl_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus ();

  fir_coeff_ctrl #(.NUM_TAPS(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cfg_start  (cfg_start),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .coeff_wr_en(coeff_wr_en),
    .coeff_idx  (coeff_idx),
    .coeff_w    (coeff_w)
  );

  // Behavioural filter: one-deep output register, y = sum(c[k]*x[n-k]) >>> 15.
  logic signed [CW-1:0] mc [N];
  logic signed [DW-1:0] dl [N-1];
  logic                 mv;
  logic [DW-1:0]        md;
  logic signed [39:0]   acc;

  assign bus.fir_s_tready = !mv || bus.fir_m_tready;
  assign bus.fir_m_tvalid = mv;
  assign bus.fir_m_tdata  = md;

  always_comb begin
    acc = 40'(mc[0]) * 40'($signed(bus.fir_s_tdata));
    for (int k = 1; k < N; k++) acc = acc + 40'(mc[k]) * 40'(dl[k-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv <= 1'b0;
      md <= '0;
      for (int k = 0; k < N-1; k++) dl[k] <= '0;
      for (int k = 0; k < N; k++) mc[k] <= '0;
    end else begin
      if (coeff_wr_en) mc[coeff_idx] <= coeff_w;
      if (bus.fir_m_tready) mv <= 1'b0;
      if (bus.fir_s_tvalid && bus.fir_s_tready) begin
        mv    <= 1'b1;
        md    <= acc[30:15];
        dl[0] <= $signed(bus.fir_s_tdata);
        for (int k = 1; k < N-1; k++) dl[k] <= dl[k-1];
      end
    end
  end

  // Monitor, sampled on the falling edge.
  int            cyc = 0, n_wr = 0, busy_cnt = 0, up_cnt = 0, dn_cnt = 0;
  int            wr_cyc [256];
  logic [IW-1:0] wr_idx [256];
  logic [CW-1:0] wr_w   [256];
  logic [DW-1:0] dn_data[256];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (coeff_wr_en) begin
      wr_idx[n_wr[7:0]] <= coeff_idx;
      wr_w[n_wr[7:0]]   <= coeff_w;
      wr_cyc[n_wr[7:0]] <= cyc;
      n_wr              <= n_wr + 1;
    end
    if (cfg_busy) busy_cnt <= busy_cnt + 1;
    if (bus.up_tvalid && bus.up_tready) up_cnt <= up_cnt + 1;
    if (bus.dn_tvalid && bus.dn_tready) begin
      dn_data[dn_cnt[7:0]] <= bus.dn_tdata;
      dn_cnt               <= dn_cnt + 1;
    end
  end

  typedef struct {
    logic [15:0] coef [4];
    int          nb;
    int          lp;
    int          exp_wr;
    int          exp_err;
    int          exp_busy;
  } rl_vec_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } imp_t;

  rl_vec_t vecs [4];
  imp_t    imp  [4];
  int      n_assert = 0;
  int      n_fail   = 0;
  int      b_wr, b_busy, b_up, b_dn, up_k, g;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic drive_coeffs(input int vi, input int nb, input int lp);
    for (int i = 0; i < nb; i++) begin
      bit hs;
      int guard;
      hs    = 1'b0;
      guard = 0;
      bus.c_tvalid = 1'b1;
      bus.c_tdata  = vecs[vi].coef[i];
      bus.c_tlast  = (i == lp);
      while (!hs && guard < 100) begin
        @(negedge clk);
        hs = bus.c_tready;
        @(posedge clk);
        #1;
        guard++;
      end
      chk("coeff_beat_accepted", int'(hs), 1);
    end
    bus.c_tvalid = 1'b0;
    bus.c_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    int guard;
    seen  = 1'b0;
    guard = 0;
    while (!seen && guard < 200) begin
      @(negedge clk);
      seen = cfg_done;
      if (seen) chk("busy_low_with_done", int'(cfg_busy), 0);
      guard++;
    end
    chk("done_seen", int'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_up(input logic [15:0] d);
    bit hs;
    int guard;
    hs    = 1'b0;
    guard = 0;
    bus.up_tvalid = 1'b1;
    bus.up_tdata  = d;
    while (!hs && guard < 100) begin
      @(negedge clk);
      hs = bus.up_tready;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("up_beat_accepted", int'(hs), 1);
    bus.up_tvalid = 1'b0;
  endtask

  task automatic reload(input int vi);
    int bw, bb, nw;
    bw = n_wr;
    bb = busy_cnt;
    start_pulse();
    chk("err_cleared_on_start", int'(cfg_err), 0);
    chk("busy_after_start", int'(cfg_busy), 1);
    drive_coeffs(vi, vecs[vi].nb, vecs[vi].lp);
    wait_done();
    nw = n_wr - bw;
    chk("cfg_err_final", int'(cfg_err), vecs[vi].exp_err);
    chk("write_count", nw, vecs[vi].exp_wr);
    for (int k = 0; k < vecs[vi].exp_wr && k < nw; k++) begin
      chk("write_idx", int'(wr_idx[8'(bw + k)]), k);
      chk("write_data", int'(wr_w[8'(bw + k)]), int'(vecs[vi].coef[k]));
      if (k > 0) chk("write_consecutive", wr_cyc[8'(bw + k)] - wr_cyc[8'(bw + k - 1)], 1);
    end
    chk("busy_cycles", busy_cnt - bb, vecs[vi].exp_busy);
    @(negedge clk);
    chk("done_one_cycle", int'(cfg_done), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].coef = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    vecs[0].nb = 4; vecs[0].lp = 3;  vecs[0].exp_wr = 4; vecs[0].exp_err = 0;
    vecs[1].coef = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};
    vecs[1].nb = 2; vecs[1].lp = 1;  vecs[1].exp_wr = 2; vecs[1].exp_err = 1;
    vecs[2].coef = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    vecs[2].nb = 4; vecs[2].lp = -1; vecs[2].exp_wr = 4; vecs[2].exp_err = 1;
    vecs[3].coef = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
    vecs[3].nb = 4; vecs[3].lp = 3;  vecs[3].exp_wr = 4; vecs[3].exp_err = 0;
`ifdef FIR_COEFF_CTRL_FLUSH_EN
    // HALT + LOAD + 4 FLUSH + 2 DRAIN (last flush output) + DONE
    vecs[0].exp_busy = 12; vecs[1].exp_busy = 10; vecs[2].exp_busy = 12; vecs[3].exp_busy = 12;
`else
    vecs[0].exp_busy = 6;  vecs[1].exp_busy = 4;  vecs[2].exp_busy = 6;  vecs[3].exp_busy = 6;
`endif
    imp[0] = '{x: 16'h7FFF, y: 16'h3FFF};
    imp[1] = '{x: 16'h0000, y: 16'h1FFF};
    imp[2] = '{x: 16'h0000, y: 16'h0FFF};
    imp[3] = '{x: 16'h0000, y: 16'h07FF};

    rst           = 1'b1;
    cfg_start     = 1'b0;
    bus.c_tvalid  = 1'b0;
    bus.c_tdata   = '0;
    bus.c_tlast   = 1'b0;
    bus.up_tvalid = 1'b1;
    bus.up_tdata  = 16'h0055;
    bus.dn_tready = 1'b1;
    repeat (3) step();
    #1;
    chk("rst_busy", int'(cfg_busy), 0);
    chk("rst_done", int'(cfg_done), 0);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_wr_en", int'(coeff_wr_en), 0);
    chk("rst_idx", int'(coeff_idx), 0);
    chk("rst_w", int'(coeff_w), 0);
    chk("rst_c_tready", int'(bus.c_tready), 0);
    chk("rst_up_tready", int'(bus.up_tready), 1);
    chk("rst_fir_s_tvalid", int'(bus.fir_s_tvalid), 1);
    chk("rst_fir_s_tdata", int'(bus.fir_s_tdata), 16'h0055);
    bus.up_tvalid = 1'b0;
    rst = 1'b0;
    step();

    // Reload scenarios, with the impulse response after the first one
    reload(0);
    b_dn = dn_cnt;
    for (int i = 0; i < 4; i++) send_up(imp[i].x);
    g = 0;
    while (dn_cnt - b_dn < 4 && g < 20) begin step(); g++; end
    chk("impulse_out_count", dn_cnt - b_dn, 4);
    for (int i = 0; i < 4; i++) chk("impulse_out", int'(dn_data[8'(b_dn + i)]), int'(imp[i].y));
    step();
    for (int v = 1; v < 4; v++) begin
      reload(v);
      step();
    end

    // Reload under continuous upstream traffic
    b_up = up_cnt;
    b_dn = dn_cnt;
    fork
      begin
        up_k = 0;
        bus.up_tvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
          bus.up_tdata = 16'(up_k);
          @(negedge clk);
          if (bus.up_tready) up_k++;
          @(posedge clk);
          #1;
        end
        bus.up_tvalid = 1'b0;
      end
      begin
        step();
        step();
        step();
        start_pulse();
        #1;
        chk("up_tready_low_after_start", int'(bus.up_tready), 0);
        drive_coeffs(0, 4, 3);
        wait_done();
      end
    join
    repeat (10) step();
    chk("up_traffic_flowed", int'(up_cnt - b_up > 20), 1);
    chk("dn_count_eq_up_count", dn_cnt - b_dn, up_cnt - b_up);

    // HALT holds while a filter output is stuck downstream
    bus.dn_tready = 1'b0;
    send_up(16'h1234);
    step();
    chk("dn_pending", int'(bus.dn_tvalid), 1);
    b_wr = n_wr;
    start_pulse();
    bus.c_tvalid = 1'b1;
    bus.c_tdata  = vecs[0].coef[0];
    bus.c_tlast  = 1'b0;
    repeat (5) step();
    chk("halt_busy", int'(cfg_busy), 1);
    chk("halt_c_tready", int'(bus.c_tready), 0);
    chk("halt_up_tready", int'(bus.up_tready), 0);
    chk("halt_no_writes", n_wr - b_wr, 0);
    bus.dn_tready = 1'b1;
    drive_coeffs(0, 4, 3);
    wait_done();
    chk("halt_then_writes", n_wr - b_wr, 4);
    chk("halt_then_err", int'(cfg_err), 0);
    step();

    // Reset in the middle of LOAD, then a clean reload from idx 0
    b_wr = n_wr;
    start_pulse();
    drive_coeffs(2, 2, -1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_writes_issued", n_wr - b_wr, 2);
    chk("midrst_busy", int'(cfg_busy), 0);
    chk("midrst_wr_en", int'(coeff_wr_en), 0);
    chk("midrst_idx", int'(coeff_idx), 0);
    chk("midrst_w", int'(coeff_w), 0);
    chk("midrst_c_tready", int'(bus.c_tready), 0);
    chk("midrst_run_up_tready", int'(bus.up_tready), 1);
    step();
    reload(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
